// File: rtl/hl_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hl_byte_sequencer
// Purpose  : Serializes a 16-bit word (2*BYTE_W) into two BYTE_W bytes over a
//            valid/ready byte stream. The module drives the high/low byte mux
//            select and holds the word stable while each byte is accepted.
//            After the second byte, an optional idle gap of GAP_CYCLES cycles
//            can be inserted before the next word is accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_word   in   word to serialize (2*BYTE_W)
//   in_vld    in   producer has a word
//   in_rdy    out  block can accept a word (registered, high only in IDLE)
//   mux_sel   out  0 = low byte selected, 1 = high byte selected
//   out_data  out  selected byte of the held word (BYTE_W)
//   out_vld   out  out_data valid
//   out_rdy   in   consumer accepts the byte
//   busy      out  any state other than IDLE
//   word_cnt  out  fully sent words, wraps 255 -> 0
// Build option
//   HL_SEQ_MSB_FIRST_EN : when defined, the high byte is sent first, and
//                         mux_sel resets to 1 and idles at 1.
// ============================================================================
module hl_byte_sequencer #(
    parameter int BYTE_W     = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*BYTE_W-1:0] in_word,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic                mux_sel,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                busy,
    output logic [7:0]          word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND_L = 2'd1,
        S_SEND_H = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // The byte order is selected only by the order in which the two send states are visited.
`ifdef HL_SEQ_MSB_FIRST_EN
    localparam state_t c_FIRST_ST  = S_SEND_H;
    localparam state_t c_SECOND_ST = S_SEND_L;
`else
    localparam state_t c_FIRST_ST  = S_SEND_L;
    localparam state_t c_SECOND_ST = S_SEND_H;
`endif

    localparam bit         c_HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0] c_GAP_LOAD = c_HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t              r_state;
    state_t              w_next_state;
    logic [2*BYTE_W-1:0] r_held;
    logic                r_in_rdy;
    logic [7:0]          r_gap_cnt;
    logic [7:0]          w_gap_cnt_nxt;
    logic [7:0]          r_word_cnt;
    logic                w_capture;
    logic                w_word_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_capture     = 1'b0;
        w_word_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // in_rdy is always high in IDLE, so in_vld alone completes the handshake.
                if (in_vld) begin
                    w_capture    = 1'b1;
                    w_next_state = c_FIRST_ST;
                end
            end
            S_SEND_L, S_SEND_H: begin
                if (out_rdy) begin
                    if (r_state == c_FIRST_ST) begin
                        w_next_state = c_SECOND_ST;
                    end else begin
                        w_word_done = 1'b1;
                        if (c_HAS_GAP) begin
                            w_next_state  = S_GAP;
                            w_gap_cnt_nxt = c_GAP_LOAD;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_held     <= '0;
            r_in_rdy   <= 1'b1;
            r_gap_cnt  <= 8'd0;
            r_word_cnt <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_gap_cnt_nxt;
            // in_rdy is computed from the next state, so it is a flop output with no
            // combinational path from in_vld or out_rdy.
            r_in_rdy  <= (w_next_state == S_IDLE);
            if (w_capture) begin
                r_held <= in_word;
            end
            if (w_word_done) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded only from registered state and the held word
    // ------------------------------------------------------------------
`ifdef HL_SEQ_MSB_FIRST_EN
    assign mux_sel = (r_state != S_SEND_L);
`else
    assign mux_sel = (r_state == S_SEND_H);
`endif

    assign out_data = mux_sel ? r_held[2*BYTE_W-1:BYTE_W] : r_held[BYTE_W-1:0];
    assign out_vld  = (r_state == S_SEND_L) || (r_state == S_SEND_H);
    assign busy     = (r_state != S_IDLE);
    assign in_rdy   = r_in_rdy;
    assign word_cnt = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hl_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hl_byte_sequencer
// Purpose  : Self-checking bench for hl_byte_sequencer. Instance A has no gap.
//            Instance B has GAP_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hl_byte_sequencer;

`ifdef HL_SEQ_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif
    localparam int GAP_G = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_in_word = '0;
    logic        a_in_vld  = 1'b0;
    logic        a_out_rdy = 1'b0;
    logic        a_in_rdy, a_mux_sel, a_out_vld, a_busy;
    logic [7:0]  a_out_data, a_word_cnt;

    logic [15:0] b_in_word = '0;
    logic        b_in_vld  = 1'b0;
    logic        b_out_rdy = 1'b0;
    logic        b_in_rdy, b_mux_sel, b_out_vld, b_busy;
    logic [7:0]  b_out_data, b_word_cnt;

    hl_byte_sequencer #(.BYTE_W(8), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_word(a_in_word), .in_vld(a_in_vld),
        .in_rdy(a_in_rdy), .mux_sel(a_mux_sel), .out_data(a_out_data),
        .out_vld(a_out_vld), .out_rdy(a_out_rdy), .busy(a_busy), .word_cnt(a_word_cnt)
    );

    hl_byte_sequencer #(.BYTE_W(8), .GAP_CYCLES(GAP_G)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_word(b_in_word), .in_vld(b_in_vld),
        .in_rdy(b_in_rdy), .mux_sel(b_mux_sel), .out_data(b_out_data),
        .out_vld(b_out_vld), .out_rdy(b_out_rdy), .busy(b_busy), .word_cnt(b_word_cnt)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt_a = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte order from the spec rules: low first by default, high first in the macro build.
    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return MSB_FIRST ? w[15:8] : w[7:0];
    endfunction
    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return MSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    // This task is called at a negedge while instance A is idle. It sends one word at full rate.
    task automatic send_a(input logic [15:0] w, input logic [7:0] b0, input logic [7:0] b1,
                          input logic s0);
        chk("a_idle_in_rdy", a_in_rdy, 1);
        a_in_word = w;
        a_in_vld  = 1'b1;
        a_out_rdy = 1'b1;
        @(negedge clk);
        a_in_vld  = 1'b0;
        a_in_word = 16'($urandom);
        chk("a_byte0_data", a_out_data, b0);
        chk("a_byte0_sel", a_mux_sel, s0);
        chk("a_byte0_vld", a_out_vld, 1);
        chk("a_byte0_in_rdy", a_in_rdy, 0);
        @(negedge clk);
        chk("a_byte1_data", a_out_data, b1);
        chk("a_byte1_sel", a_mux_sel, !s0);
        chk("a_byte1_vld", a_out_vld, 1);
        @(negedge clk);
        exp_cnt_a = exp_cnt_a + 8'd1;
        chk("a_done_vld", a_out_vld, 0);
        chk("a_done_in_rdy", a_in_rdy, 1);
        chk("a_done_busy", a_busy, 0);
        chk("a_done_cnt", a_word_cnt, exp_cnt_a);
        chk("a_done_sel", a_mux_sel, MSB_FIRST);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_cnt_a = 8'd0;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        s0;
    } vec_t;
    vec_t tbl [5];

    typedef struct {
        logic [7:0] data;
        logic       sel;
    } byte_t;
    byte_t       q[$];
    int          gap_m;
    logic [7:0]  cnt_m;
    logic        exp_rdy;
    logic [15:0] w_tmp;
    int          last_cap, n_cap, n_low;

    initial begin
`ifdef HL_SEQ_MSB_FIRST_EN
        tbl[0] = '{16'hA55A, 8'hA5, 8'h5A, 1'b1};
        tbl[1] = '{16'hBEEF, 8'hBE, 8'hEF, 1'b1};
        tbl[2] = '{16'h1234, 8'h12, 8'h34, 1'b1};
        tbl[3] = '{16'h0000, 8'h00, 8'h00, 1'b1};
        tbl[4] = '{16'hFF01, 8'hFF, 8'h01, 1'b1};
`else
        tbl[0] = '{16'hA55A, 8'h5A, 8'hA5, 1'b0};
        tbl[1] = '{16'hBEEF, 8'hEF, 8'hBE, 1'b0};
        tbl[2] = '{16'h1234, 8'h34, 8'h12, 1'b0};
        tbl[3] = '{16'h0000, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{16'hFF01, 8'h01, 8'hFF, 1'b0};
`endif

        // Check the outputs while reset is held.
        #2;
        chk("rst_a_vld", a_out_vld, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_cnt", a_word_cnt, 0);
        chk("rst_a_sel", a_mux_sel, MSB_FIRST);
        chk("rst_b_vld", b_out_vld, 0);
        chk("rst_b_sel", b_mux_sel, MSB_FIRST);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_in_rdy", a_in_rdy, 1);
        chk("rst_b_in_rdy", b_in_rdy, 1);

        // Run the table-driven full-rate words.
        for (int i = 0; i < 5; i++) begin
            send_a(tbl[i].word, tbl[i].b0, tbl[i].b1, tbl[i].s0);
        end

        // Apply reset while the second byte is pending, then drop the partial word.
        a_in_word = 16'hC3A7;
        a_in_vld  = 1'b1;
        a_out_rdy = 1'b1;
        @(negedge clk);
        a_in_vld = 1'b0;
        @(negedge clk);
        a_out_rdy = 1'b0;
        chk("mid_pre_vld", a_out_vld, 1);
        chk("mid_pre_sel", a_mux_sel, !MSB_FIRST);
        chk("mid_pre_cnt", a_word_cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", a_out_vld, 0);
        chk("mid_rst_sel", a_mux_sel, MSB_FIRST);
        chk("mid_rst_cnt", a_word_cnt, 0);
        chk("mid_rst_busy", a_busy, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_cnt_a = 8'd0;
        @(negedge clk);
        chk("mid_rel_in_rdy", a_in_rdy, 1);
        chk("mid_rel_vld", a_out_vld, 0);

        // Apply backpressure on the first byte while in_word changes underneath.
        a_in_word = 16'h1234;
        a_in_vld  = 1'b1;
        a_out_rdy = 1'b0;
        @(negedge clk);
        a_in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", a_out_data, first_byte(16'h1234));
            chk("bp_hold_vld", a_out_vld, 1);
            chk("bp_hold_sel", a_mux_sel, MSB_FIRST);
            a_in_word = 16'hFFFF;
            @(negedge clk);
        end
        a_out_rdy = 1'b1;
        chk("bp_last_first", a_out_data, first_byte(16'h1234));
        @(negedge clk);
        chk("bp_second", a_out_data, second_byte(16'h1234));
        chk("bp_second_sel", a_mux_sel, !MSB_FIRST);
        @(negedge clk);
        exp_cnt_a = exp_cnt_a + 8'd1;
        chk("bp_done_cnt", a_word_cnt, exp_cnt_a);
        chk("bp_done_in_rdy", a_in_rdy, 1);

        // Test word counter wrap: 255, 256 and 257 words after reset.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            w_tmp = 16'($urandom);
            send_a(w_tmp, first_byte(w_tmp), second_byte(w_tmp), MSB_FIRST);
        end
        chk("wrap_255", a_word_cnt, 255);
        w_tmp = 16'($urandom);
        send_a(w_tmp, first_byte(w_tmp), second_byte(w_tmp), MSB_FIRST);
        chk("wrap_256", a_word_cnt, 0);
        w_tmp = 16'($urandom);
        send_a(w_tmp, first_byte(w_tmp), second_byte(w_tmp), MSB_FIRST);
        chk("wrap_257", a_word_cnt, 1);

        // Check gap spacing: in_vld and out_rdy held high, so captures occur every 3+GAP cycles.
        do_reset();
        b_in_vld  = 1'b1;
        b_out_rdy = 1'b1;
        last_cap  = -1;
        n_cap     = 0;
        n_low     = 0;
        for (int c = 0; c < 40; c++) begin
            b_in_word = 16'($urandom);
            if (b_in_rdy) begin
                if (last_cap >= 0) begin
                    chk("gap_spacing", c - last_cap, 3 + GAP_G);
                    chk("gap_rdy_low", n_low, 2 + GAP_G);
                end
                last_cap = c;
                n_cap++;
                n_low = 0;
            end else begin
                n_low++;
            end
            @(negedge clk);
        end
        chk("gap_captures", n_cap, 7);

        // Drive random traffic on the gap instance against a queue-based reference.
        b_in_vld  = 1'b0;
        b_out_rdy = 1'b0;
        do_reset();
        q.delete();
        gap_m = 0;
        cnt_m = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            exp_rdy = (q.size() == 0) && (gap_m == 0);
            chk("m_in_rdy", b_in_rdy, exp_rdy);
            chk("m_busy", b_busy, !exp_rdy);
            chk("m_out_vld", b_out_vld, q.size() != 0);
            chk("m_word_cnt", b_word_cnt, cnt_m);
            if (q.size() != 0) begin
                chk("m_out_data", b_out_data, q[0].data);
                chk("m_mux_sel", b_mux_sel, q[0].sel);
            end else begin
                chk("m_idle_sel", b_mux_sel, MSB_FIRST);
            end
            b_in_word = 16'($urandom);
            b_in_vld  = ($urandom_range(0, 9) < 6);
            b_out_rdy = ($urandom_range(0, 9) < 6);
            if (q.size() != 0) begin
                if (b_out_rdy) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        cnt_m = cnt_m + 8'd1;
                        gap_m = GAP_G;
                    end
                end
            end else if (gap_m > 0) begin
                gap_m--;
            end else if (b_in_vld) begin
                if (MSB_FIRST) begin
                    q.push_back('{b_in_word[15:8], 1'b1});
                    q.push_back('{b_in_word[7:0], 1'b0});
                end else begin
                    q.push_back('{b_in_word[7:0], 1'b0});
                    q.push_back('{b_in_word[15:8], 1'b1});
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
